// File: rtl/sam6883_gen_if.sv
// SAM bus bundle: CPU address/strobe inputs, VDG sync/fetch inputs, and the clock,
// select, RAM-address and control-register outputs of the MC6883 replacement.
interface sam6883_gen_if #(
  parameter int ADDR_W = 16
);
  logic [15:0]       cpu_addr;
  logic              cpu_rw;
  logic              da0;
  logic              hs_n;
  logic              fs_n;
  logic              e;
  logic              q;
  logic [2:0]        s;
  logic [ADDR_W-1:0] z;
  logic [ADDR_W-1:0] vaddr;
  logic              vclk_ena;
  logic [15:0]       sam_reg;

  modport master (
    output cpu_addr, cpu_rw, da0, hs_n, fs_n,
    input  e, q, s, z, vaddr, vclk_ena, sam_reg
  );

  modport slave (
    input  cpu_addr, cpu_rw, da0, hs_n, fs_n,
    output e, q, s, z, vaddr, vclk_ena, sam_reg
  );
endinterface

// File: rtl/sam6883_gen.sv
// MC6883 SAM replacement: E/Q generation with slow/fast rate, 74138 select decode,
// CPU/video RAM address mux, VDG address generator and the FFC0-FFDF control register.
module sam6883_gen #(
  parameter int          CLK_DIV  = 16,
  parameter int          ADDR_W   = 16,
  parameter logic [15:0] REG_INIT = '0
) (
  input logic           clk,
  input logic           reset,
  sam6883_gen_if.slave  bus
);
  localparam int unsigned PH_W = $clog2(CLK_DIV);
  localparam int unsigned NS   = CLK_DIV;
  localparam int unsigned NF   = CLK_DIV / 2;
  localparam logic [ADDR_W-1:0] F_INIT = ADDR_W'({REG_INIT[9:3], 9'b0});

  typedef enum logic {RATE_SLOW, RATE_FAST} rate_t;

  rate_t             rate, rate_nxt;
  logic [PH_W-1:0]   ph, ph_last, ph_q0, ph_q1, ph_e0;
  logic              wrap, e_i, q_i;
  logic [15:0]       lat_addr;
  logic              lat_rw;
  logic [2:0]        s_r;
  logic [ADDR_W-1:0] zc_r;
  logic [15:0]       sam_reg;

  logic [2:0]        da0_sy, hs_sy, fs_sy;
  logic              da0_rise, hs_fall, fs_fall;
  logic [ADDR_W-1:0] vaddr, row_start;
  logic              xcnt, xlast;
  logic [3:0]        ycnt, ylast;
  logic [2:0]        v_act;
  logic              vclk;

  function automatic logic [ADDR_W-1:0] mem_mask(input logic [1:0] m);
    if (m == 2'b00) return ADDR_W'(12'hFFF);
    if (m == 2'b01) return ADDR_W'(14'h3FFF);
    return '1;
  endfunction

  function automatic logic [2:0] dec_s(input logic [15:0] a, input logic ty);
    if (a >= 16'hFFF0) return 3'd2;
    if (a >= 16'hFF60) return 3'd7;
    if (a >= 16'hFF40) return 3'd6;
    if (a >= 16'hFF20) return 3'd5;
    if (a >= 16'hFF00) return 3'd4;
    if (ty)            return 3'd0;
    if (a >= 16'hC000) return 3'd3;
    if (a >= 16'hA000) return 3'd2;
    if (a >= 16'h8000) return 3'd1;
    return 3'd0;
  endfunction

  // Vector fetches map to BFF0-BFFF regardless of the memory-size mask.
  function automatic logic [ADDR_W-1:0] cpu_z(input logic [15:0] a, input logic ty,
                                              input logic p, input logic [1:0] m);
    logic [15:0] t;
    t = a;
    if (a >= 16'hFFF0) return ADDR_W'({12'hBFF, a[3:0]});
    if (!ty && !a[15]) t[15] = p;
    return ADDR_W'(t) & mem_mask(m);
  endfunction

  always_comb begin
    if (rate == RATE_FAST) begin
      ph_last = PH_W'(NF - 1);
      ph_q0   = PH_W'(NF / 4);
      ph_q1   = PH_W'(3 * NF / 4);
      ph_e0   = PH_W'(NF / 2);
    end else begin
      ph_last = PH_W'(NS - 1);
      ph_q0   = PH_W'(NS / 4);
      ph_q1   = PH_W'(3 * NS / 4);
      ph_e0   = PH_W'(NS / 2);
    end
  end

  assign wrap = (ph == ph_last);
  assign e_i  = (ph >= ph_e0);
  assign q_i  = (ph >= ph_q0) && (ph < ph_q1);

  // Rate is chosen only at the wrap, from the register as it stood before any write landing there.
  always_comb begin
    rate_nxt = rate;
    if (wrap) begin
      if (sam_reg[12])
        rate_nxt = RATE_FAST;
      else if (sam_reg[11] && bus.cpu_addr >= 16'h8000 && bus.cpu_addr <= 16'hFEFF)
        rate_nxt = RATE_FAST;
      else
        rate_nxt = RATE_SLOW;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rate <= RATE_SLOW;
    else       rate <= rate_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ph       <= '0;
      lat_addr <= '0;
      lat_rw   <= 1'b1;
      s_r      <= 3'd7;
      zc_r     <= '0;
      sam_reg  <= REG_INIT;
    end else begin
      ph <= wrap ? '0 : ph + 1'b1;
      if (ph == ph_q0) begin
        lat_addr <= bus.cpu_addr;
        lat_rw   <= bus.cpu_rw;
        s_r      <= dec_s(bus.cpu_addr, sam_reg[15]);
        zc_r     <= cpu_z(bus.cpu_addr, sam_reg[15], sam_reg[10], sam_reg[14:13]);
      end
      if (wrap && !lat_rw && lat_addr[15:5] == 11'h7FE)
        sam_reg[lat_addr[4:1]] <= lat_addr[0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      da0_sy <= '0;
      hs_sy  <= '1;
      fs_sy  <= '1;
    end else begin
      da0_sy <= {da0_sy[1:0], bus.da0};
      hs_sy  <= {hs_sy[1:0], bus.hs_n};
      fs_sy  <= {fs_sy[1:0], bus.fs_n};
    end
  end

  assign da0_rise = da0_sy[1] & ~da0_sy[2];
  assign hs_fall  = ~hs_sy[1] & hs_sy[2];
  assign fs_fall  = ~fs_sy[1] & fs_sy[2];

  always_comb begin
    xlast = (v_act == 3'b001) || (v_act == 3'b011);
    case (v_act)
      3'b000:  ylast = 4'd11;
      3'b001:  ylast = 4'd2;
      3'b010:  ylast = 4'd2;
      3'b011:  ylast = 4'd1;
      3'b100:  ylast = 4'd1;
      default: ylast = 4'd0;
    endcase
  end

  // Priority fs > hs > da0 drops coincident lower-priority events.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vaddr     <= F_INIT;
      row_start <= F_INIT;
      xcnt      <= 1'b0;
      ycnt      <= '0;
      v_act     <= REG_INIT[2:0];
      vclk      <= 1'b0;
    end else begin
      vclk <= 1'b0;
      if (fs_fall) begin
        vaddr     <= ADDR_W'({sam_reg[9:3], 9'b0});
        row_start <= ADDR_W'({sam_reg[9:3], 9'b0});
        xcnt      <= 1'b0;
        ycnt      <= '0;
        v_act     <= sam_reg[2:0];
      end else if (hs_fall && v_act != 3'b111) begin
        xcnt <= 1'b0;
        if (ycnt == ylast) begin
          ycnt      <= '0;
          row_start <= vaddr;
        end else begin
          ycnt  <= ycnt + 1'b1;
          vaddr <= row_start;
        end
      end else if (da0_rise) begin
        if (xcnt == xlast) begin
          xcnt  <= 1'b0;
          vaddr <= vaddr + 1'b1;
          vclk  <= 1'b1;
        end else begin
          xcnt <= xcnt + 1'b1;
        end
      end
    end
  end

  assign bus.e        = e_i;
  assign bus.q        = q_i;
  assign bus.s        = s_r;
  assign bus.z        = e_i ? zc_r : (vaddr & mem_mask(sam_reg[14:13]));
  assign bus.vaddr    = vaddr;
  assign bus.vclk_ena = vclk;
  assign bus.sam_reg  = sam_reg;
endmodule

// File: tb/tb_sam6883_gen.sv
// Directed and randomized bench for sam6883_gen against an arithmetic reference of
// E/Q timing, select/address decode, control register and VDG address generation.
module tb_sam6883_gen;
  logic clk = 1'b0;
  logic reset;

  sam6883_gen_if #(.ADDR_W(16)) bus();

  sam6883_gen #(.CLK_DIV(16), .ADDR_W(16), .REG_INIT(16'h0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [15:0] reg_m;
  int          n_cur;
  logic [15:0] mv_vaddr, mv_row;
  int          mv_x, mv_y;
  int          mv_v;
  int          xdiv_t [8] = '{1, 2, 1, 2, 1, 1, 1, 1};
  int          yrep_t [8] = '{12, 3, 3, 2, 2, 1, 1, 1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic int m_sel(input int a, input bit ty);
    int i;
    if (a >= 'hFFF0) return 2;
    if (a >= 'hFF00) begin
      i = (a - 'hFF00) / 32;
      return (i >= 3) ? 7 : 4 + i;
    end
    if (ty || a < 'h8000) return 0;
    if (a >= 'hC000) return 3;
    return 1 + (a - 'h8000) / 'h2000;
  endfunction

  function automatic int m_size(input logic [1:0] m);
    return (m == 0) ? 4096 : (m == 1) ? 16384 : 65536;
  endfunction

  function automatic int m_z(input int a, input logic [15:0] r);
    int v;
    if (a >= 'hFFF0) return a - 'h4000;
    v = a;
    if (!r[15] && a < 'h8000 && r[10]) v = v + 'h8000;
    return v % m_size(r[14:13]);
  endfunction

  function automatic int m_len(input logic [15:0] r, input int a);
    int rr;
    rr = r[12:11];
    if (rr == 0) return 16;
    if (rr == 1) return (a >= 'h8000 && a <= 'hFEFF) ? 8 : 16;
    return 8;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    bus.cpu_addr = 16'h0000;
    bus.cpu_rw = 1'b1;
    bus.da0 = 1'b0;
    bus.hs_n = 1'b1;
    bus.fs_n = 1'b1;
    reg_m = '0; n_cur = 16;
    mv_vaddr = '0; mv_row = '0; mv_x = 0; mv_y = 0; mv_v = 0;
    repeat (2) @(negedge clk);
    chk("rst.e", bus.e, 0);
    chk("rst.q", bus.q, 0);
    chk("rst.s", bus.s, 7);
    chk("rst.z", bus.z, 0);
    chk("rst.vaddr", bus.vaddr, 0);
    chk("rst.vclk", bus.vclk_ena, 0);
    chk("rst.reg", bus.sam_reg, 0);
    reset = 1'b0;
  endtask

  // One E cycle starting at the negedge of phase 0; next address is presented once E is high.
  task automatic cycle(input logic [15:0] ca, input logic crw, input logic [15:0] na, input logic nrw);
    int k, qr, er, len, idx, nn;
    logic pe;
    bus.cpu_addr = ca;
    bus.cpu_rw = crw;
    k = 0; qr = -1; er = -1; len = -1;
    pe = bus.e;
    while (len < 0 && k < 40) begin
      @(negedge clk);
      k++;
      if (bus.q && qr < 0) qr = k;
      if (bus.e && er < 0) begin
        er = k;
        chk("cyc.s", bus.s, m_sel(ca, reg_m[15]));
        chk("cyc.z", bus.z, m_z(ca, reg_m));
        bus.cpu_addr = na;
        bus.cpu_rw = nrw;
      end
      if (pe && !bus.e) len = k;
      pe = bus.e;
    end
    chk("cyc.qrise", qr, n_cur / 4);
    chk("cyc.erise", er, n_cur / 2);
    chk("cyc.len", len, n_cur);
    nn = m_len(reg_m, na);
    if (!crw && ca >= 16'hFFC0 && ca <= 16'hFFDF) begin
      idx = (int'(ca) - 'hFFC0) / 2;
      reg_m[idx] = ca[0];
    end
    n_cur = nn;
    chk("cyc.reg", bus.sam_reg, reg_m);
  endtask

  task automatic resync();
    logic pe;
    int found;
    found = 0;
    pe = bus.e;
    for (int k = 0; k < 40 && found == 0; k++) begin
      @(negedge clk);
      if (pe && !bus.e) found = 1;
      pe = bus.e;
    end
    chk("resync", found, 1);
  endtask

  task automatic pulse_da0();
    int cnt, ep;
    cnt = 0;
    bus.da0 = 1'b1;
    repeat (4) begin @(negedge clk); cnt += int'(bus.vclk_ena); end
    bus.da0 = 1'b0;
    repeat (4) begin @(negedge clk); cnt += int'(bus.vclk_ena); end
    mv_x++;
    ep = 0;
    if (mv_x == xdiv_t[mv_v]) begin mv_x = 0; mv_vaddr = mv_vaddr + 16'd1; ep = 1; end
    chk("da0.vaddr", bus.vaddr, mv_vaddr);
    chk("da0.vclk", cnt, ep);
    if (!bus.e) chk("vid.z", bus.z, int'(mv_vaddr) % m_size(reg_m[14:13]));
  endtask

  task automatic pulse_hs();
    bus.hs_n = 1'b0;
    repeat (4) @(negedge clk);
    bus.hs_n = 1'b1;
    repeat (4) @(negedge clk);
    if (mv_v != 7) begin
      mv_x = 0;
      mv_y++;
      if (mv_y == yrep_t[mv_v]) begin mv_y = 0; mv_row = mv_vaddr; end
      else mv_vaddr = mv_row;
    end
    chk("hs.vaddr", bus.vaddr, mv_vaddr);
  endtask

  task automatic pulse_fs();
    bus.fs_n = 1'b0;
    repeat (4) @(negedge clk);
    bus.fs_n = 1'b1;
    repeat (4) @(negedge clk);
    mv_vaddr = 16'(int'(reg_m[9:3]) * 512);
    mv_row = mv_vaddr; mv_x = 0; mv_y = 0; mv_v = int'(reg_m[2:0]);
    chk("fs.vaddr", bus.vaddr, mv_vaddr);
  endtask

  logic [15:0] ra [41];
  logic        rw [41];
  logic [15:0] wa [5];

  initial begin
    reset = 1'b1;
    do_reset();

    // Slow timing, then R=11 via FFD7/FFD9
    cycle(16'h0000, 1'b1, 16'hFFD7, 1'b0);
    cycle(16'hFFD7, 1'b0, 16'hFFD9, 1'b0);
    cycle(16'hFFD9, 1'b0, 16'h0000, 1'b1);
    cycle(16'h0000, 1'b1, 16'h0000, 1'b1);
    chk("r11.pending_len", n_cur, 8);
    cycle(16'h0000, 1'b1, 16'h0000, 1'b1);
    cycle(16'h0000, 1'b1, 16'h0000, 1'b1);

    // R=01 address-dependent rate
    do_reset();
    cycle(16'h0000, 1'b1, 16'hFFD7, 1'b0);
    cycle(16'hFFD7, 1'b0, 16'h0000, 1'b1);
    cycle(16'h0000, 1'b1, 16'h8123, 1'b1);
    cycle(16'h8123, 1'b1, 16'h0400, 1'b1);
    cycle(16'h0400, 1'b1, 16'h0000, 1'b1);

    // M=00, P=1, vector remap
    do_reset();
    cycle(16'h0000, 1'b1, 16'hFFD5, 1'b0);
    cycle(16'hFFD5, 1'b0, 16'h3FFF, 1'b1);
    cycle(16'h3FFF, 1'b1, 16'hFFFE, 1'b1);
    cycle(16'hFFFE, 1'b1, 16'h0000, 1'b1);
    chk("p.reg", bus.sam_reg, 16'h0400);

    // Random CPU traffic with register writes mixed in
    do_reset();
    for (int i = 0; i < 41; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        ra[i] = 16'hFFC0 + 16'($urandom_range(0, 31));
        rw[i] = 1'b0;
      end else begin
        ra[i] = 16'($urandom);
        rw[i] = 1'($urandom_range(0, 1));
      end
    end
    ra[0] = 16'h0000; rw[0] = 1'b1;
    for (int i = 0; i < 40; i++) cycle(ra[i], rw[i], ra[i+1], rw[i+1]);

    // Reset mid-cycle during an FFDF write
    do_reset();
    cycle(16'h0000, 1'b1, 16'hFFDF, 1'b0);
    for (int k = 0; k < 40 && !bus.e; k++) @(negedge clk);
    chk("mid.e_high", bus.e, 1);
    reset = 1'b1;
    #1;
    chk("mid.e", bus.e, 0);
    chk("mid.s", bus.s, 7);
    chk("mid.ty", bus.sam_reg[15], 0);
    @(negedge clk);
    do_reset();

    // Video: F bit2, V=000 row repeat
    cycle(16'h0000, 1'b1, 16'hFFCB, 1'b0);
    cycle(16'hFFCB, 1'b0, 16'h0000, 1'b1);
    cycle(16'h0000, 1'b1, 16'h0000, 1'b1);
    pulse_fs();
    chk("vid.base", bus.vaddr, 16'h0800);
    for (int i = 0; i < 32; i++) pulse_da0();
    for (int h = 0; h < 11; h++) begin
      pulse_hs();
      chk("vid.repeat", bus.vaddr, 16'h0800);
      for (int i = 0; i < 32; i++) pulse_da0();
    end
    pulse_hs();
    chk("vid.advance", bus.vaddr, 16'h0820);
    for (int i = 0; i < 5; i++) pulse_da0();
    pulse_hs();
    chk("vid.newrow", bus.vaddr, 16'h0820);

    // Random video frames with random V and F
    for (int f = 0; f < 4; f++) begin
      int v, j;
      v = $urandom_range(0, 7);
      j = $urandom_range(0, 6);
      for (int b = 0; b < 3; b++) wa[b] = 16'hFFC0 + 16'(2 * b) + 16'((v >> b) & 1);
      wa[3] = 16'hFFC0 + 16'(2 * (3 + j)) + 16'($urandom_range(0, 1));
      wa[4] = 16'h0000;
      resync();
      cycle(16'h0000, 1'b1, wa[0], 1'b0);
      for (int b = 0; b < 4; b++) cycle(wa[b], 1'b0, wa[b+1], (b == 3));
      pulse_fs();
      for (int ev = 0; ev < 50; ev++) begin
        if ($urandom_range(0, 3) == 0) pulse_hs();
        else pulse_da0();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
